// File: rtl/key_pulse_conditioner_pkg.sv
// Shared state codes and 50 MHz timing defaults for the key pulse conditioner.
package key_pulse_conditioner_pkg;

  typedef logic [1:0] kpc_state_t;

  localparam kpc_state_t ST_RELEASED    = 2'd0;
  localparam kpc_state_t ST_PRESS_CHK   = 2'd1;
  localparam kpc_state_t ST_HELD        = 2'd2;
  localparam kpc_state_t ST_RELEASE_CHK = 2'd3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  function automatic int unsigned kpc_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_pulse_conditioner_if.sv
// Key input and conditioned pulse outputs between the board and the counter datapath.
interface key_pulse_conditioner_if;
  logic KeyN;
  logic RepeatEn;
  logic Pressed;
  logic CountEn;
  logic ReleasePulse;

  modport master (output KeyN, output RepeatEn,
                  input  Pressed, input CountEn, input ReleasePulse);
  modport slave  (input  KeyN, input RepeatEn,
                  output Pressed, output CountEn, output ReleasePulse);
endinterface

// File: rtl/key_sync2.sv
// Two-flop synchroniser with asynchronous active-low reset to a configurable idle level.
module key_sync2 #(
  parameter logic IDLE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb sync_d = {sync_q[0], d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {2{IDLE}};
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/key_pulse_conditioner.sv
// Debounces an active-low pushbutton into a held level, press/auto-repeat
// count-enable pulses and a release pulse, all registered.
module key_pulse_conditioner
  import key_pulse_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input logic                      Clock,
  input logic                      Resetn,
  key_pulse_conditioner_if.slave   bus
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RPT_W = $clog2(kpc_max(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);

  kpc_state_t       state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             pressed_q, pressed_d;
  logic             count_en_q, count_en_d;
  logic             release_pulse_q, release_pulse_d;
  logic             key_sync_n;
  logic             key_s;

  key_sync2 #(.IDLE(1'b1)) u_sync (
    .clk   (Clock),
    .rst_n (Resetn),
    .d     (bus.KeyN),
    .q     (key_sync_n)
  );

  assign key_s = ~key_sync_n;

  always_comb begin
    state_d         = state_q;
    db_cnt_d        = db_cnt_q;
    rpt_cnt_d       = rpt_cnt_q;
    count_en_d      = 1'b0;
    release_pulse_d = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (key_s) begin
          state_d  = ST_PRESS_CHK;
          db_cnt_d = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!key_s) begin
          state_d = ST_RELEASED;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = ST_HELD;
          rpt_cnt_d  = '0;
          count_en_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        // rpt_cnt tracks the index of the next HELD cycle; after the first
        // repeat it folds back to REPEAT_DELAY instead of running on.
        if (!key_s) begin
          state_d  = ST_RELEASE_CHK;
          db_cnt_d = '0;
        end else if (!bus.RepeatEn) begin
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == RPT_LAST) begin
          rpt_cnt_d  = RPT_FIRST;
          count_en_d = 1'b1;
        end else begin
          rpt_cnt_d  = rpt_cnt_q + 1'b1;
          count_en_d = (rpt_cnt_q + 1'b1 == RPT_FIRST);
        end
      end
      ST_RELEASE_CHK: begin
        if (key_s) begin
          state_d = ST_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          state_d         = ST_RELEASED;
          release_pulse_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
    pressed_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_CHK);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q         <= ST_RELEASED;
      db_cnt_q        <= '0;
      rpt_cnt_q       <= '0;
      pressed_q       <= 1'b0;
      count_en_q      <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      db_cnt_q        <= db_cnt_d;
      rpt_cnt_q       <= rpt_cnt_d;
      pressed_q       <= pressed_d;
      count_en_q      <= count_en_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign bus.Pressed      = pressed_q;
  assign bus.CountEn      = count_en_q;
  assign bus.ReleasePulse = release_pulse_q;

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// Directed bench for key_pulse_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_key_pulse_conditioner;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  key_pulse_conditioner_if bus ();

  key_pulse_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // {Pressed, CountEn, ReleasePulse}
  function automatic int outs();
    return int'({bus.Pressed, bus.CountEn, bus.ReleasePulse});
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_count(input int n, output int pc, output int ce, output int rp);
    pc = 0; ce = 0; rp = 0;
    for (int i = 0; i < n; i++) begin
      step();
      pc += int'(bus.Pressed);
      ce += int'(bus.CountEn);
      rp += int'(bus.ReleasePulse);
    end
  endtask

  initial begin
    int pc, ce, rp;
    total = 0;
    bad   = 0;
    rst_n        = 1'b0;
    bus.KeyN     = 1'b0;
    bus.RepeatEn = 1'b0;

    // Reset with key held, then press emerges 7 edges after release of reset
    steps(3);
    chk("reset_outs", outs(), 0);
    rst_n = 1'b1;
    steps(6);
    chk("press_e6", outs(), 0);
    step();
    chk("press_e7", outs(), 3'b110);
    step();
    chk("press_e8", outs(), 3'b100);

    // Held with RepeatEn=0: no further pulses
    run_count(50, pc, ce, rp);
    chk("norep_pulses", ce, 0);
    chk("norep_pressed", pc, 50);

    // Clean release
    bus.KeyN = 1'b1;
    steps(6);
    chk("rel_e6", outs(), 3'b100);
    step();
    chk("rel_e7", outs(), 3'b001);
    step();
    chk("rel_e8", outs(), 0);

    // Press bounce: low 2, high 1, ten times
    for (int r = 0; r < 10; r++) begin
      bus.KeyN = 1'b0;
      steps(2);
      chk("bounce_pr", int'(bus.Pressed), 0);
      chk("bounce_ce", int'(bus.CountEn), 0);
      bus.KeyN = 1'b1;
      step();
    end
    run_count(8, pc, ce, rp);
    chk("bounce_tail_pc", pc, 0);
    chk("bounce_tail_ce", ce, 0);

    // Release glitch while held
    bus.KeyN = 1'b0;
    steps(7);
    chk("press2_e7", outs(), 3'b110);
    steps(5);
    bus.KeyN = 1'b1;
    steps(2);
    bus.KeyN = 1'b0;
    run_count(10, pc, ce, rp);
    chk("glitch_rp", rp, 0);
    chk("glitch_pc", pc, 10);
    chk("glitch_ce", ce, 0);
    bus.KeyN = 1'b1;
    run_count(10, pc, ce, rp);
    chk("rel2_rp", rp, 1);
    chk("rel2_end", outs(), 0);

    // Auto-repeat held 30 cycles: pulses after E7, E15, E18, ...
    bus.RepeatEn = 1'b1;
    bus.KeyN     = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      chk($sformatf("rep_e%0d", k), int'(bus.CountEn),
          int'((k == 7) || (k >= 15 && (k - 15) % 3 == 0)));
    end
    bus.KeyN = 1'b1;
    run_count(10, pc, ce, rp);
    chk("rep_rel_rp", rp, 1);

    // RepeatEn dropped after E16 for 5 cycles
    bus.KeyN = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("drop_e%0d", k), int'(bus.CountEn),
          int'((k == 7) || (k == 15) || (k >= 29 && (k - 29) % 3 == 0)));
      if (k == 16) bus.RepeatEn = 1'b0;
      if (k == 21) bus.RepeatEn = 1'b1;
    end
    bus.KeyN = 1'b1;
    run_count(10, pc, ce, rp);
    chk("drop_rel_rp", rp, 1);

    // Reset mid-HELD aborts without a release pulse
    bus.RepeatEn = 1'b0;
    bus.KeyN     = 1'b0;
    steps(12);
    chk("mid_held", outs(), 3'b100);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async", outs(), 0);
    run_count(2, pc, ce, rp);
    chk("mid_rst_rp", rp, 0);
    chk("mid_rst_pc", pc, 0);
    rst_n = 1'b1;
    steps(6);
    chk("mid_post_e6", outs(), 0);
    step();
    chk("mid_post_e7", outs(), 3'b110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_pulse_conditioner.md
Name: key_pulse_conditioner

Overview:
Upstream conditioning stage for the board-level counter/hex-display datapath. Takes a raw active-low pushbutton, synchronises and debounces it, and produces a clean debounced level plus single-cycle count-enable pulses. Optional auto-repeat generates further pulses while the key is held. The 16-bit counter therefore runs on the system clock with this pulse as its enable, instead of being clocked directly by a bouncing key.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable synchronised samples required to accept a press or release; 10 ms at 50 MHz; must be >= 1.
REPEAT_DELAY, 25000000, HELD cycles before the first auto-repeat pulse; must be >= 1.
REPEAT_PERIOD, 5000000, HELD cycles between subsequent auto-repeat pulses; must be >= 1.

Ports:
Clock      in   1   system clock; all state is rising-edge triggered.
Resetn     in   1   asynchronous, active-low reset.
KeyN       in   1   raw pushbutton, active-low, asynchronous to Clock.
RepeatEn   in   1   1 = auto-repeat enabled while held; synchronous.
Pressed    out  1   debounced key level, 1 = held.
CountEn    out  1   one-cycle enable pulse for the downstream counter.
ReleasePulse out 1  one-cycle pulse on accepted release.

Behaviour:
- Reset: one clock, Clock; reset Resetn is asynchronous and active-low. While Resetn = 0:
  - Synchroniser flops reset to the released value (1).
  - FSM resets to RELEASED; all counters reset to 0.
  - Pressed, CountEn and ReleasePulse are 0.
  - Reset asserted mid-press aborts everything; no ReleasePulse is emitted.
- Synchroniser: two flops on KeyN; key_s = inverted second-flop output.
- FSM states RELEASED, PRESS_CHK, HELD, RELEASE_CHK:
  - RELEASED: if key_s = 1, go to PRESS_CHK and set db_cnt = 0.
  - PRESS_CHK: if key_s = 0, return to RELEASED (bounce; no outputs). Otherwise db_cnt increments. When db_cnt = DEBOUNCE_CYCLES-1 and key_s = 1, go to HELD and set rpt_cnt = 0.
  - HELD: if key_s = 0, go to RELEASE_CHK and set db_cnt = 0.
  - RELEASE_CHK: if key_s = 1, return to HELD (bounce). Otherwise db_cnt increments. When db_cnt = DEBOUNCE_CYCLES-1, go to RELEASED.
- Latency: KeyN low is first sampled at edge E1, key_s = 1 after E2, PRESS_CHK is entered at E3, and HELD is entered at E(3+DEBOUNCE_CYCLES). Release latency is symmetric.
- Pressed is 1 exactly when the state is HELD or RELEASE_CHK (registered).
- CountEn:
  - 1 during the first cycle in HELD after PRESS_CHK (the press pulse).
  - Auto-repeat: while in HELD with RepeatEn = 1, rpt_cnt increments each cycle.
  - Additional CountEn pulses occur at HELD-cycle indices REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, REPEAT_DELAY+2*REPEAT_PERIOD, ... Index 0 is the press-pulse cycle.
  - RepeatEn = 0 clears rpt_cnt; it restarts from 0 when RepeatEn returns to 1.
  - rpt_cnt holds its value during RELEASE_CHK. A bounce back to HELD resumes the count with no extra pulse.
  - rpt_cnt never wraps: after REPEAT_DELAY it reloads within the period window.
- ReleasePulse: 1 for exactly one cycle, the first cycle in RELEASED after RELEASE_CHK.
- CountEn and ReleasePulse are never asserted in the same cycle.
- All outputs are registered; there are no combinational paths from inputs.
- Counter widths are $clog2 of the largest governing parameter, plus 1.

Decomposition:
- Shared package: the state enum (RELEASED, PRESS_CHK, HELD, RELEASE_CHK) and default timing constants (debounce, repeat delay, repeat period for a 50 MHz clock).
- One sub-module, key_sync2: a two-flop synchroniser with asynchronous active-low reset to a parameterised idle value.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- Reset: Resetn=0 with KeyN=0 held -> Pressed=CountEn=ReleasePulse=0; after release of Resetn, Pressed rises 7 edges later.
- Clean press, RepeatEn=0: KeyN falls before E1 and stays low -> Pressed=1 and a single CountEn pulse after E7; no further pulses over 50 cycles. Release -> ReleasePulse 7 edges after KeyN rises, then Pressed=0.
- Bounce rejection: KeyN low for 2 cycles, high for 1, repeated 10 times -> CountEn and Pressed stay 0. A release glitch of KeyN high for 2 cycles while held -> no ReleasePulse, Pressed stays 1.
- Auto-repeat, RepeatEn=1, held 30 cycles -> CountEn pulses in the cycles after E7, E15, E18, E21, E24, ...
- RepeatEn dropped after E16 for 5 cycles -> no pulses in that window; next pulse 8 cycles after RepeatEn returns.
- Reset mid-HELD: Resetn pulsed low at E12 -> all outputs 0 immediately, no ReleasePulse. With KeyN still low, a new press pulse occurs 7 edges after Resetn deasserts.
